// File: rtl/qr_sequencer.sv
// qr_sequencer
//   Runs ITER back-to-back ChaCha20 quarter rounds on four captured words by
//   sequencing an external combinational half-step unit. Each quarter round
//   takes four half-steps, one per clock. The result is then offered over a
//   valid/ready handshake.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid/in_ready     input handshake; in_a..in_d captured in IDLE only
//   out_valid/out_ready   result handshake; out_a..out_d valid while DONE
//   busy                  high in RUN and DONE
//   dp_x, dp_y, dp_z      half-step operands (sum = x + y, rot from z ^ sum)
//   dp_sht                rotate-amount code (0:16 1:20 2:24 3:25, rotate right)
//   dp_sum, dp_rot        half-step results, registered at the end of the step
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for input words, in_ready high
// RUN   | one half-step per cycle, step 0..3, repeated ITER times
// DONE  | result presented, held until out_ready

module qr_sequencer #(
  parameter int ITER = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_c,
  input  logic [31:0] in_d,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [31:0] out_c,
  output logic [31:0] out_d,
  output logic        busy,
  output logic [31:0] dp_x,
  output logic [31:0] dp_y,
  output logic [31:0] dp_z,
  output logic [1:0]  dp_sht,
  input  logic [31:0] dp_sum,
  input  logic [31:0] dp_rot
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] ITER_LAST = 8'(ITER - 1);

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [1:0]  step_q, step_d;
  logic [7:0]  iter_q, iter_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      step_q  <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      step_q  <= step_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    step_d  = step_q;
    iter_d  = iter_q;
    dp_x    = '0;
    dp_y    = '0;
    dp_z    = '0;
    dp_sht  = '0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          c_d     = in_c;
          d_d     = in_d;
          step_d  = '0;
          iter_d  = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        dp_sht = step_q;
        // Even steps update the (A, D) pair, odd steps the (C, B) pair.
        if (!step_q[0]) begin
          dp_x = a_q;
          dp_y = b_q;
          dp_z = d_q;
          a_d  = dp_sum;
          d_d  = dp_rot;
        end else begin
          dp_x = c_q;
          dp_y = d_q;
          dp_z = b_q;
          c_d  = dp_sum;
          b_d  = dp_rot;
        end
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          if (iter_q == ITER_LAST) begin
            state_d = DONE;
          end else begin
            iter_d = iter_q + 8'd1;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_c     = c_q;
  assign out_d     = d_q;

endmodule

// File: tb/tb_qr_sequencer.sv
module tb_qr_sequencer;

  localparam logic [31:0] IA = 32'h11111111, IB = 32'h01020304,
                          IC = 32'h9b8d6f43, ID = 32'h01234567;
  localparam logic [31:0] OA = 32'hea2a92f4, OB = 32'hcb1cf8ce,
                          OC = 32'h4581472e, OD = 32'h5881c4bb;

  function automatic logic [31:0] rotr_code(input logic [31:0] v, input logic [1:0] code);
    int n;
    case (code)
      2'd0:    n = 16;
      2'd1:    n = 20;
      2'd2:    n = 24;
      default: n = 25;
    endcase
    return (v >> n) | (v << (32 - n));
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Textbook ChaCha20 quarter round, packed {a, b, c, d}.
  function automatic logic [127:0] ref_qr(input logic [127:0] w);
    logic [31:0] a, b, c, d;
    {a, b, c, d} = w;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ITER=1 instance
  logic        iv1, ir1, ov1, or1, busy1;
  logic [31:0] ia1, ib1, ic1, id1, oa1, ob1, oc1, od1;
  logic [31:0] x1, y1, z1, sum1, rot1;
  logic [1:0]  sht1;
  assign sum1 = x1 + y1;
  assign rot1 = rotr_code(z1 ^ sum1, sht1);

  qr_sequencer #(.ITER(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv1), .in_ready(ir1),
    .in_a(ia1), .in_b(ib1), .in_c(ic1), .in_d(id1),
    .out_valid(ov1), .out_ready(or1),
    .out_a(oa1), .out_b(ob1), .out_c(oc1), .out_d(od1),
    .busy(busy1),
    .dp_x(x1), .dp_y(y1), .dp_z(z1), .dp_sht(sht1),
    .dp_sum(sum1), .dp_rot(rot1)
  );

  // ITER=2 instance
  logic        iv2, ir2, ov2, or2, busy2;
  logic [31:0] ia2, ib2, ic2, id2, oa2, ob2, oc2, od2;
  logic [31:0] x2, y2, z2, sum2, rot2;
  logic [1:0]  sht2;
  assign sum2 = x2 + y2;
  assign rot2 = rotr_code(z2 ^ sum2, sht2);

  qr_sequencer #(.ITER(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(iv2), .in_ready(ir2),
    .in_a(ia2), .in_b(ib2), .in_c(ic2), .in_d(id2),
    .out_valid(ov2), .out_ready(or2),
    .out_a(oa2), .out_b(ob2), .out_c(oc2), .out_d(od2),
    .busy(busy2),
    .dp_x(x2), .dp_y(y2), .dp_z(z2), .dp_sht(sht2),
    .dp_sum(sum2), .dp_rot(rot2)
  );

  // Present one word set to dut1 for a single cycle; called just after a
  // rising edge while dut1 is idle. Returns just after the accepting edge.
  task automatic drive1(input logic [31:0] a, b, c, d);
    iv1 = 1'b1; ia1 = a; ib1 = b; ic1 = c; id1 = d;
    @(posedge clk); #1;
    iv1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ir1 !== 1'b1 || ov1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b, want 1 0 0", ir1, ov1, busy1);
    end
    checks++;
    if ({oa1, ob1, oc1, od1} !== 128'd0) begin
      errors++;
      $display("FAIL reset_out: got %h want 0", {oa1, ob1, oc1, od1});
    end
    checks++;
    if ({x1, y1, z1} !== 96'd0 || sht1 !== 2'd0) begin
      errors++;
      $display("FAIL reset_dp: got x=%h y=%h z=%h sht=%0d want 0", x1, y1, z1, sht1);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_rfc_vector();
    int cnt;
    checks++;
    if (ir1 !== 1'b1) begin
      errors++;
      $display("FAIL rfc_ready: in_ready=%b want 1", ir1);
    end
    drive1(IA, IB, IC, ID);
    checks++;
    if (x1 !== IA || y1 !== IB || z1 !== ID) begin
      errors++;
      $display("FAIL step0_operands: got x=%h y=%h z=%h want %h %h %h", x1, y1, z1, IA, IB, ID);
    end
    cnt = 0;
    while (ov1 !== 1'b1 && cnt < 20) begin
      checks++;
      if (sht1 !== 2'(cnt) || ir1 !== 1'b0) begin
        errors++;
        $display("FAIL step_seq: cycle %0d sht=%0d in_ready=%b want sht=%0d in_ready=0", cnt, sht1, ir1, cnt % 4);
      end
      @(posedge clk); #1;
      cnt++;
    end
    checks++;
    if (cnt != 4) begin
      errors++;
      $display("FAIL rfc_latency: got %0d cycles want 4", cnt);
    end
    checks++;
    if ({oa1, ob1, oc1, od1} !== {OA, OB, OC, OD}) begin
      errors++;
      $display("FAIL rfc_result: got %h want %h", {oa1, ob1, oc1, od1}, {OA, OB, OC, OD});
    end
    @(posedge clk); #1;
    checks++;
    if (ov1 !== 1'b0 || ir1 !== 1'b1) begin
      errors++;
      $display("FAIL rfc_release: out_valid=%b in_ready=%b want 0 1", ov1, ir1);
    end
  endtask

  task automatic test_backpressure();
    int cnt;
    or1 = 1'b0;
    drive1(IA, IB, IC, ID);
    cnt = 0;
    while (ov1 !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    checks++;
    if (cnt != 4) begin
      errors++;
      $display("FAIL bp_latency: got %0d cycles want 4", cnt);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ov1 !== 1'b1 || ir1 !== 1'b0 || {oa1, ob1, oc1, od1} !== {OA, OB, OC, OD}) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d out_valid=%b in_ready=%b out=%h want 1 0 %h",
                 i, ov1, ir1, {oa1, ob1, oc1, od1}, {OA, OB, OC, OD});
      end
    end
    or1 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ov1 !== 1'b0 || ir1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b want 0 1 0", ov1, ir1, busy1);
    end
  endtask

  task automatic test_reset_mid_run();
    int cnt;
    drive1(32'hdeadbeef, 32'h12345678, 32'h0badf00d, 32'hcafebabe);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (sht1 !== 2'd2 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL mid_step2: sht=%0d busy=%b want 2 1", sht1, busy1);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ov1 !== 1'b0 || ir1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_flags: out_valid=%b in_ready=%b busy=%b want 0 1 0", ov1, ir1, busy1);
    end
    checks++;
    if ({oa1, ob1, oc1, od1} !== 128'd0 || {x1, y1, z1} !== 96'd0 || sht1 !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset_regs: out=%h dp=%h sht=%0d want 0", {oa1, ob1, oc1, od1}, {x1, y1, z1}, sht1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    drive1(IA, IB, IC, ID);
    cnt = 0;
    while (ov1 !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    checks++;
    if (cnt != 4 || {oa1, ob1, oc1, od1} !== {OA, OB, OC, OD}) begin
      errors++;
      $display("FAIL after_reset_job: cycles=%0d out=%h want 4 %h", cnt, {oa1, ob1, oc1, od1}, {OA, OB, OC, OD});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_input_while_busy();
    int cnt;
    drive1(IA, IB, IC, ID);
    @(posedge clk); #1;
    iv1 = 1'b1;
    ia1 = 32'hffffffff; ib1 = 32'h00000001; ic1 = 32'h55555555; id1 = 32'haaaaaaaa;
    @(posedge clk); #1;
    iv1 = 1'b0;
    cnt = 2;
    while (ov1 !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    checks++;
    if (cnt != 4 || {oa1, ob1, oc1, od1} !== {OA, OB, OC, OD}) begin
      errors++;
      $display("FAIL busy_ignore: cycles=%0d out=%h want 4 %h", cnt, {oa1, ob1, oc1, od1}, {OA, OB, OC, OD});
    end
    @(posedge clk); #1;
    checks++;
    if (ir1 !== 1'b1 || ov1 !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_idle: in_ready=%b out_valid=%b want 1 0", ir1, ov1);
    end
  endtask

  task automatic test_iter2();
    int cnt;
    logic [127:0] exp;
    exp = ref_qr({OA, OB, OC, OD});
    iv2 = 1'b1; ia2 = IA; ib2 = IB; ic2 = IC; id2 = ID;
    @(posedge clk); #1;
    iv2 = 1'b0;
    cnt = 0;
    while (ov2 !== 1'b1 && cnt < 30) begin
      checks++;
      if (busy2 !== 1'b1 || sht2 !== 2'(cnt)) begin
        errors++;
        $display("FAIL iter2_run: cycle %0d busy=%b sht=%0d want 1 %0d", cnt, busy2, sht2, cnt % 4);
      end
      @(posedge clk); #1;
      cnt++;
    end
    checks++;
    if (cnt != 8) begin
      errors++;
      $display("FAIL iter2_latency: got %0d cycles want 8", cnt);
    end
    checks++;
    if ({oa2, ob2, oc2, od2} !== exp || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL iter2_result: got %h busy=%b want %h busy=1", {oa2, ob2, oc2, od2}, busy2, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (ov2 !== 1'b0 || ir2 !== 1'b1) begin
      errors++;
      $display("FAIL iter2_release: out_valid=%b in_ready=%b want 0 1", ov2, ir2);
    end
  endtask

  initial begin
    iv1 = 1'b0; or1 = 1'b1; ia1 = '0; ib1 = '0; ic1 = '0; id1 = '0;
    iv2 = 1'b0; or2 = 1'b1; ia2 = '0; ib2 = '0; ic2 = '0; id2 = '0;
    test_reset();
    test_rfc_vector();
    test_backpressure();
    test_reset_mid_run();
    test_input_while_busy();
    test_iter2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/qr_sequencer.md
Name: qr_sequencer

Overview:
- Controller that runs a full ChaCha20 quarter round on the team's shared combinational half-step unit.
- The half-step unit computes sum = x + y and rot = rotr(z ^ sum, amount), where the 2-bit amount code selects 0→16, 1→20, 2→24, 3→25 (equivalent to rotl 16, 12, 8, 7).
- The block accepts four 32-bit words over a valid/ready handshake and drives the unit for four half-steps per quarter round.
- It repeats the quarter round ITER times, then presents the result over a valid/ready handshake.

Parameters:
- ITER, 1, number of back-to-back quarter rounds applied to the captured words before output (legal range 1..255).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input words valid.
- in_ready  out  1  block can accept input.
- in_a, in_b, in_c, in_d  in  32 each  quarter-round input words.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_a, out_b, out_c, out_d  out  32 each  result words.
- busy  out  1  high while RUN or DONE.
- dp_x, dp_y, dp_z  out  32 each  operands to the half-step unit (adder inputs x, y; xor input z).
- dp_sht  out  2  rotate-amount code to the half-step unit.
- dp_sum  in  32  half-step unit sum result.
- dp_rot  in  32  half-step unit rotate result.

Behaviour:
- Reset (async, rst=1): state=IDLE; A/B/C/D registers=0; step=0; iter counter=0.
  - Outputs: in_ready=1, out_valid=0, busy=0, out_*=0, dp_*=0.
- State IDLE: in_ready=1.
  - On in_valid&&in_ready, capture in_a..in_d into A..D, set step=0 and iter=0, go to RUN.
- State RUN: in_ready=0. Each cycle drives one half-step combinationally from registers; the result is registered at the clock edge.
  - step0: dp_x=A, dp_y=B, dp_z=D, dp_sht=0 → A←dp_sum, D←dp_rot.
  - step1: dp_x=C, dp_y=D, dp_z=B, dp_sht=1 → C←dp_sum, B←dp_rot.
  - step2: dp_x=A, dp_y=B, dp_z=D, dp_sht=2 → A←dp_sum, D←dp_rot.
  - step3: dp_x=C, dp_y=D, dp_z=B, dp_sht=3 → C←dp_sum, B←dp_rot.
  - step is a 2-bit counter and wraps 3→0.
  - At step3, if iter==ITER-1, go to DONE; otherwise iter++ and continue at step0.
- Outside RUN, dp_x/dp_y/dp_z=0 and dp_sht=0. dp_* values are don't-care functionally but must be deterministic.
- State DONE: out_valid=1 and out_a..out_d=A..D, held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE; in_ready rises the next cycle. There is no same-cycle accept in DONE.
- Latency: 4*ITER clocks from the input-accept edge to out_valid high. Throughput is one job per 4*ITER+2 cycles minimum.
- Arithmetic: all adds are mod 2^32 and are performed in the external unit. This block does no arithmetic except on its counters.
- in_valid while busy is ignored; inputs are not sampled outside IDLE.
- out_ready held high continuously: DONE lasts exactly one cycle.
- out_ready low: result held indefinitely, with no state or data change.
- Reset asserted mid-RUN or in DONE: immediate return to reset values. The partial result is discarded and out_valid drops asynchronously.
- iter counter width is 8 bits. ITER=1 means a single quarter round with no extra loop.

Test Plan:
- RFC 7539 §2.1.1 vector, ITER=1: in a=11111111 b=01020304 c=9b8d6f43 d=01234567 → out_valid exactly 4 cycles after accept; out a=ea2a92f4 b=cb1cf8ce c=4581472e d=5881c4bb.
- Sequencing check, same vector: dp_sht must be 0,1,2,3 on consecutive RUN cycles. Step0 must show dp_x=11111111, dp_y=01020304, dp_z=01234567.
- ITER=2 with the same input: out_valid 8 cycles after accept; result equals the §2.1.1 output fed again through one reference quarter round; busy high throughout.
- Backpressure: out_ready=0 for 10 cycles in DONE → outputs stable and in_ready=0. Then out_ready=1 → out_valid falls next cycle and in_ready=1.
- Reset mid-operation: assert rst at RUN step2 → out_valid=0, in_ready=1, all registers 0. A fresh job afterwards produces the correct §2.1.1 result.
- Input during busy: pulse in_valid with different words at RUN step1 → ignored; the original job result is unchanged.
